// File: rtl/tc_timer_counter_bank_pkg.sv
// Shared constants and type codes for the timer/counter execution bank.
package tc_timer_counter_bank_pkg;

  localparam int TC_ACC_LEN  = 16;
  localparam int TC_NUMBERS  = 8;
  localparam int TC_TYPE_LEN = 3;
  localparam int TC_ADDR_LEN = 3;

  // Codes 3, 6 and 7 are reserved: a slot carrying one idles with state held.
  typedef enum logic [TC_TYPE_LEN-1:0] {
    TC_TON = 3'd0,
    TC_TOF = 3'd1,
    TC_TP  = 3'd2,
    TC_CTU = 3'd4,
    TC_CTD = 3'd5
  } tc_type_e;

endpackage

// File: rtl/tc_timer_counter_bank_channel.sv
// One timer/counter slot: preset, accumulator, done and pulse-running state.
module tc_channel
  import tc_timer_counter_bank_pkg::*;
#(
  parameter int ACC_W = TC_ACC_LEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [TC_TYPE_LEN-1:0] type_code,
  input  logic                   tick,
  input  logic                   tc_in,
  input  logic                   preset_we,
  input  logic [ACC_W-1:0]       preset_val,
  input  logic                   clr,
  output logic [ACC_W-1:0]       acc,
  output logic                   done
);

  logic [ACC_W-1:0] preset_r;
  logic [ACC_W-1:0] acc_r;
  logic             done_r;
  logic             running_r;
  logic             in_reg_r;
  logic             in_prev_r;

  logic             rise_s;
  logic [ACC_W:0]   acc_inc_s;
  logic [ACC_W:0]   preset_ext_s;
  logic             acc_ge_s;
  logic             inc_ge_s;
  logic             acc_max_s;
  logic             acc_zero_s;

  assign rise_s       = in_reg_r & ~in_prev_r;
  assign acc_inc_s    = {1'b0, acc_r} + {{ACC_W{1'b0}}, 1'b1};
  assign preset_ext_s = {1'b0, preset_r};
  assign acc_ge_s     = ({1'b0, acc_r} >= preset_ext_s);
  assign inc_ge_s     = (acc_inc_s >= preset_ext_s);
  assign acc_max_s    = &acc_r;
  assign acc_zero_s   = ~|acc_r;

  // Input edge sampling and preset storage; unaffected by clear or enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_reg_r  <= 1'b0;
      in_prev_r <= 1'b0;
      preset_r  <= '0;
    end else begin
      in_reg_r  <= tc_in;
      in_prev_r <= in_reg_r;
      if (preset_we) begin
        preset_r <= preset_val;
      end
    end
  end

  // Slot behaviour: clear beats disable beats the per-type rules.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r     <= '0;
      done_r    <= 1'b0;
      running_r <= 1'b0;
    end else if (clr) begin
      running_r <= 1'b0;
      if (type_code == TC_CTD) begin
        acc_r  <= preset_r;
        done_r <= (preset_r == {ACC_W{1'b0}});
      end else begin
        acc_r  <= '0;
        done_r <= 1'b0;
      end
    end else if (!en) begin
      acc_r     <= '0;
      done_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      case (type_code)
        TC_TON: begin
          if (!in_reg_r) begin
            acc_r  <= '0;
            done_r <= 1'b0;
          end else if (acc_ge_s) begin
            done_r <= 1'b1;
          end else if (tick) begin
            acc_r  <= acc_inc_s[ACC_W-1:0];
            done_r <= inc_ge_s;
          end
        end
        TC_TOF: begin
          if (in_reg_r) begin
            acc_r  <= '0;
            done_r <= 1'b1;
          end else if (done_r) begin
            if (acc_ge_s) begin
              done_r <= 1'b0;
            end else if (tick) begin
              acc_r  <= acc_inc_s[ACC_W-1:0];
              done_r <= ~inc_ge_s;
            end
          end
        end
        TC_TP: begin
          // A tick in the triggering cycle is not counted; retriggers are ignored.
          if (running_r) begin
            if (acc_ge_s) begin
              running_r <= 1'b0;
              done_r    <= 1'b0;
            end else if (tick) begin
              acc_r <= acc_inc_s[ACC_W-1:0];
              if (inc_ge_s) begin
                running_r <= 1'b0;
                done_r    <= 1'b0;
              end
            end
          end else if (rise_s) begin
            running_r <= 1'b1;
            done_r    <= 1'b1;
            acc_r     <= '0;
          end else if (!in_reg_r) begin
            acc_r <= '0;
          end
        end
        TC_CTU: begin
          if (rise_s) begin
            if (!acc_max_s) begin
              acc_r <= acc_inc_s[ACC_W-1:0];
            end
            done_r <= acc_max_s ? acc_ge_s : inc_ge_s;
          end
        end
        TC_CTD: begin
          if (rise_s) begin
            if (!acc_zero_s) begin
              acc_r <= acc_r - {{(ACC_W-1){1'b0}}, 1'b1};
            end
            done_r <= acc_zero_s | (acc_r == {{(ACC_W-1){1'b0}}, 1'b1});
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign acc  = acc_r;
  assign done = done_r;

endmodule

// File: rtl/tc_timer_counter_bank.sv
// Bank of timer/counter slots with preset/clear address decode and accumulator readback.
module tc_timer_counter_bank
  import tc_timer_counter_bank_pkg::*;
#(
  parameter int ACC_W = TC_ACC_LEN,
  parameter int N     = TC_NUMBERS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             enIn,
  input  logic [N*TC_TYPE_LEN-1:0] typeIn,
  input  logic                     tick,
  input  logic [N-1:0]             tcIn,
  input  logic                     presetEn,
  input  logic                     clrEn,
  input  logic [TC_ADDR_LEN-1:0]   tcAddr,
  input  logic [ACC_W-1:0]         presetIn,
  input  logic [TC_ADDR_LEN-1:0]   rdAddr,
  output logic [N-1:0]             doneOut,
  output logic [ACC_W-1:0]         accOut
);

  logic [ACC_W-1:0] acc_s [N];

  for (genvar k = 0; k < N; k++) begin : g_slot
    logic sel_s;
    assign sel_s = (tcAddr == TC_ADDR_LEN'(k));

    tc_channel #(
      .ACC_W(ACC_W)
    ) u_channel (
      .clk        (clk),
      .reset      (reset),
      .en         (enIn[k]),
      .type_code  (typeIn[k*TC_TYPE_LEN +: TC_TYPE_LEN]),
      .tick       (tick),
      .tc_in      (tcIn[k]),
      .preset_we  (presetEn & sel_s),
      .preset_val (presetIn),
      .clr        (clrEn & sel_s),
      .acc        (acc_s[k]),
      .done       (doneOut[k])
    );
  end

  // Readback is a plain mux on registered slot state.
  assign accOut = acc_s[rdAddr];

endmodule

// File: tb/tb_tc_timer_counter_bank.sv
// Randomized and directed bench for tc_timer_counter_bank against a behavioural slot model.
module tb_tc_timer_counter_bank;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int TL = 3;
  localparam int AL = 3;
  localparam int ACC_MAX = 65535;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  enIn;
  logic [N*TL-1:0] typeIn;
  logic          tick;
  logic [N-1:0]  tcIn;
  logic          presetEn;
  logic          clrEn;
  logic [AL-1:0] tcAddr;
  logic [W-1:0]  presetIn;
  logic [AL-1:0] rdAddr;
  logic [N-1:0]  doneOut;
  logic [W-1:0]  accOut;

  int m_pre[N], m_acc[N], m_done[N], m_run[N], m_inr[N], m_inp[N];
  int checks = 0;
  int passes = 0;

  tc_timer_counter_bank dut (
    .clk(clk), .reset(reset), .enIn(enIn), .typeIn(typeIn), .tick(tick),
    .tcIn(tcIn), .presetEn(presetEn), .clrEn(clrEn), .tcAddr(tcAddr),
    .presetIn(presetIn), .rdAddr(rdAddr), .doneOut(doneOut), .accOut(accOut)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_pre[k] = 0; m_acc[k] = 0; m_done[k] = 0;
      m_run[k] = 0; m_inr[k] = 0; m_inp[k] = 0;
    end
  endtask

  // One clock edge of every slot, computed from the operating rules.
  task automatic model_step();
    if (reset == 1'b0) begin
      model_reset();
      return;
    end
    for (int k = 0; k < N; k++) begin
      int p = m_pre[k];
      int a = m_acc[k];
      int d = m_done[k];
      int r = m_run[k];
      int t = int'(typeIn[k*TL +: TL]);
      bit inr = (m_inr[k] != 0);
      bit rise = inr && (m_inp[k] == 0);
      bit sel = (int'(tcAddr) == k);
      if (clrEn && sel) begin
        r = 0;
        if (t == 5) begin a = p; d = (p == 0); end
        else begin a = 0; d = 0; end
      end else if (!enIn[k]) begin
        a = 0; d = 0; r = 0;
      end else begin
        case (t)
          0: if (!inr) begin a = 0; d = 0; end
             else if (a >= p) d = 1;
             else if (tick) begin a = a + 1; d = (a >= p); end
          1: if (inr) begin a = 0; d = 1; end
             else if (d != 0) begin
               if (a >= p) d = 0;
               else if (tick) begin a = a + 1; d = (a < p); end
             end
          2: if (r != 0) begin
               if (a >= p) begin r = 0; d = 0; end
               else if (tick) begin
                 a = a + 1;
                 if (a >= p) begin r = 0; d = 0; end
               end
             end else if (rise) begin r = 1; d = 1; a = 0; end
             else if (!inr) a = 0;
          4: if (rise) begin if (a < ACC_MAX) a = a + 1; d = (a >= p); end
          5: if (rise) begin if (a > 0) a = a - 1; d = (a == 0); end
          default: ;
        endcase
      end
      if (presetEn && sel) m_pre[k] = int'(presetIn);
      m_acc[k] = a; m_done[k] = d; m_run[k] = r;
      m_inp[k] = m_inr[k];
      m_inr[k] = int'(tcIn[k]);
    end
  endtask

  task automatic check();
    logic [N-1:0] ed;
    logic [W-1:0] ea;
    for (int k = 0; k < N; k++) ed[k] = (m_done[k] != 0);
    ea = W'(m_acc[rdAddr]);
    checks++;
    if (doneOut === ed) passes++;
    else $display("FAIL doneOut actual=%b expected=%b t=%0t", doneOut, ed, $time);
    checks++;
    if (accOut === ea) passes++;
    else $display("FAIL accOut[%0d] actual=%0d expected=%0d t=%0t", rdAddr, accOut, ea, $time);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check();
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic pin(input string name, input int dutv, input int modv, input int expv);
    checks++;
    if (dutv == expv) passes++;
    else $display("FAIL %s dut actual=%0d expected=%0d", name, dutv, expv);
    checks++;
    if (modv == expv) passes++;
    else $display("FAIL %s model actual=%0d expected=%0d", name, modv, expv);
  endtask

  task automatic set_type(input int k, input int t);
    typeIn[k*TL +: TL] = 3'(t);
  endtask

  task automatic wr_preset(input int k, input int v);
    presetEn = 1'b1; tcAddr = 3'(k); presetIn = 16'(v);
    step();
    presetEn = 1'b0;
  endtask

  task automatic clear(input int k);
    clrEn = 1'b1; tcAddr = 3'(k);
    step();
    clrEn = 1'b0;
  endtask

  task automatic run(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      tick = (period > 0) && (i % period == period - 1);
      step();
    end
    tick = 1'b0;
  endtask

  task automatic pulse(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      tcIn[k] = 1'b1; step();
      tcIn[k] = 1'b0; step();
    end
  endtask

  initial begin
    int hi, mhi;
    reset = 1'b0; enIn = '0; typeIn = '0; tick = 1'b0; tcIn = '0;
    presetEn = 1'b0; clrEn = 1'b0; tcAddr = '0; presetIn = '0; rdAddr = '0;
    model_reset();
    step(); step();
    pin("reset_done", int'(doneOut), 0, 0);
    pin("reset_acc", int'(accOut), m_acc[0], 0);
    reset = 1'b1;

    enIn = 8'b1101_1111;
    set_type(0, 0); set_type(1, 1); set_type(2, 4); set_type(3, 2);
    set_type(4, 5); set_type(5, 0); set_type(6, 4); set_type(7, 4);
    wr_preset(0, 3); wr_preset(1, 2); wr_preset(2, 10); wr_preset(3, 2);
    wr_preset(4, 2); wr_preset(5, 3); wr_preset(6, 5); wr_preset(7, 0);
    for (int k = 0; k < N; k++) clear(k);
    rdAddr = 3'd4; step();
    pin("ctd_clear_acc", int'(accOut), m_acc[4], 2);
    pin("ctd_clear_done", int'(doneOut[4]), m_done[4], 0);

    // TON slot 0
    rdAddr = 3'd0; tcIn[0] = 1'b1; run(16, 4);
    pin("ton_done", int'(doneOut[0]), m_done[0], 1);
    pin("ton_acc", int'(accOut), m_acc[0], 3);
    tcIn[0] = 1'b0; step(); step();
    pin("ton_off_done", int'(doneOut[0]), m_done[0], 0);
    pin("ton_off_acc", int'(accOut), m_acc[0], 0);

    // TOF slot 1
    rdAddr = 3'd1; tcIn[1] = 1'b1; run(3, 0);
    pin("tof_on_done", int'(doneOut[1]), m_done[1], 1);
    tcIn[1] = 1'b0; run(12, 4);
    pin("tof_off_done", int'(doneOut[1]), m_done[1], 0);
    pin("tof_off_acc", int'(accOut), m_acc[1], 2);
    tcIn[1] = 1'b1; run(2, 0);
    tcIn[1] = 1'b0; run(4, 4);
    tcIn[1] = 1'b1; run(2, 0);
    pin("tof_retrig_done", int'(doneOut[1]), m_done[1], 1);
    pin("tof_retrig_acc", int'(accOut), m_acc[1], 0);
    tcIn[1] = 1'b0;

    // TP slot 3 with retriggers inside the window
    rdAddr = 3'd3; hi = 0; mhi = 0;
    for (int i = 0; i < 12; i++) begin
      tick = (i % 4 == 3);
      tcIn[3] = (i < 6) && (i % 2 == 0);
      step();
      if (doneOut[3]) hi++;
      if (m_done[3] != 0) mhi++;
    end
    tick = 1'b0; tcIn[3] = 1'b0;
    pin("tp_width", hi, mhi, 6);

    // CTD slot 4
    rdAddr = 3'd4; pulse(4, 3);
    pin("ctd_sat_acc", int'(accOut), m_acc[4], 0);
    pin("ctd_sat_done", int'(doneOut[4]), m_done[4], 1);
    tcIn[4] = 1'b1; step();
    tcIn[4] = 1'b0; clrEn = 1'b1; tcAddr = 3'd4; step(); clrEn = 1'b0;
    pin("ctd_clr_rise_acc", int'(accOut), m_acc[4], 2);
    pin("ctd_clr_rise_done", int'(doneOut[4]), m_done[4], 0);
    presetEn = 1'b1; clrEn = 1'b1; tcAddr = 3'd4; presetIn = 16'd7; step();
    presetEn = 1'b0; clrEn = 1'b0;
    pin("ctd_old_preset", int'(accOut), m_acc[4], 2);
    clear(4);
    pin("ctd_new_preset", int'(accOut), m_acc[4], 7);

    // Disabled slot 5, reserved type on slot 6, CTU preset 0 on slot 7
    rdAddr = 3'd5; tcIn[5] = 1'b1; run(8, 1); tcIn[5] = 1'b0; pulse(5, 2);
    pin("disabled_acc", int'(accOut), m_acc[5], 0);
    rdAddr = 3'd6; pulse(6, 3); set_type(6, 7); pulse(6, 3); run(4, 1);
    pin("reserved_acc", int'(accOut), m_acc[6], 3);
    rdAddr = 3'd7; pulse(7, 1);
    pin("ctu_p0_done", int'(doneOut[7]), m_done[7], 1);

    // CTU slot 2 reset mid-count, asynchronously
    rdAddr = 3'd2; pulse(2, 5);
    pin("ctu_acc", int'(accOut), m_acc[2], 5);
    #2 reset = 1'b0;
    #1 model_reset();
    pin("async_rst_acc", int'(accOut), m_acc[2], 0);
    pin("async_rst_done", int'(doneOut), 0, 0);
    step(); step();
    reset = 1'b1;

    // Randomized traffic
    enIn = 8'($urandom);
    for (int k = 0; k < N; k++) set_type(k, $urandom_range(0, 5));
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) if ($urandom_range(0, 5) == 0) tcIn[k] = ~tcIn[k];
      presetEn = ($urandom_range(0, 11) == 0);
      clrEn = ($urandom_range(0, 11) == 0);
      tcAddr = 3'($urandom);
      presetIn = 16'($urandom_range(0, 7));
      rdAddr = 3'($urandom);
      if ($urandom_range(0, 199) == 0) enIn = 8'($urandom);
      if ($urandom_range(0, 149) == 0) set_type($urandom_range(0, 7), $urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
